id_ex_stage_reg: RTL

- Pipeline register between the decode stage (control unit + register file read) and the execute stage.
- Captures the control word, operands and register addresses each cycle.
- Detects load-use hazards against the instruction currently in EX, and inserts one bubble per hazard.
- Requests an IF/ID hold during a hazard, and honours downstream hold and branch flush.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/load_use_detect.sv | 34 +++
 rtl/id_ex_stage_reg.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline types and constants.
//   ctrl_word_t  : the ten decode control fields carried from ID to EX
//   CTRL_NOP     : all-zero control word (no RF write, no memory, no branch)
//   ALU_ADD/SUB  : ALU opcode encodings used by the decoder
//   MEM_RW_*     : mem_rw encodings (1 = store, 0 = load)
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef struct packed {
    logic       shift_imm;
    logic [3:0] alu_op;
    logic [1:0] mem_size;
    logic       mem_enable;
    logic       mem_rw;
    logic       load_inst;
    logic       s;
    logic       rf_enable;
    logic       b_instr;
    logic       b_l;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  localparam logic MEM_RW_LOAD  = 1'b0;
  localparam logic MEM_RW_STORE = 1'b1;

endpackage

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard detector. Flags when the instruction
// in ID reads a register that the load currently in EX will write.
// Ports:
//   ex_valid, ex_load_inst, ex_rf_enable, ex_rd : EX-stage instruction info
//   id_use_rn, id_rn, id_use_rm, id_rm           : ID-stage source operands
//   haz                                          : hazard flag
// ---------------------------------------------------------------------------
module load_use_detect #(
  parameter int REG_W = 4
) (
  input  logic             ex_valid,
  input  logic             ex_load_inst,
  input  logic             ex_rf_enable,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_use_rn,
  input  logic [REG_W-1:0] id_rn,
  input  logic             id_use_rm,
  input  logic [REG_W-1:0] id_rm,
  output logic             haz
);

  logic ex_is_load_wb;
  logic rn_match;
  logic rm_match;

  // A bubble (ex_valid=0) never produces a hazard. R15 is not special.
  assign ex_is_load_wb = ex_valid & ex_load_inst & ex_rf_enable;
  assign rn_match      = id_use_rn & (id_rn == ex_rd);
  assign rm_match      = id_use_rm & (id_rm == ex_rd);
  assign haz           = ex_is_load_wb & (rn_match | rm_match);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register with load-use bubble insertion, downstream hold
// and branch flush. Per-edge priority: reset > ex_hold > flush > hazard >
// normal load. An annulled instruction (id_cond_pass=0) loads as a bubble
// but its operands are still captured.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   id_* control/data    : decode-stage control word, operands, imm, regs
//   ex_hold, flush       : downstream stall, taken-branch squash
//   ex_*                 : registered copies of the id_* fields
//   ex_valid             : EX holds a real instruction
//   ifid_hold            : combinational, hold PC and IF/ID this cycle
// Optional build macro ID_EX_PERF_COUNTERS_EN adds saturating 16-bit
// bubble_cnt (hazard bubbles) and flush_cnt (flush edges) outputs.
// ---------------------------------------------------------------------------
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_shift_imm,
  input  logic [3:0]        id_alu_op,
  input  logic [1:0]        id_mem_size,
  input  logic              id_mem_enable,
  input  logic              id_mem_rw,
  input  logic              id_load_inst,
  input  logic              id_s,
  input  logic              id_rf_enable,
  input  logic              id_b_instr,
  input  logic              id_b_l,
  input  logic              id_cond_pass,
  input  logic [DATA_W-1:0] id_pa,
  input  logic [DATA_W-1:0] id_pb,
  input  logic [DATA_W-1:0] id_pd,
  input  logic [23:0]       id_imm,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [REG_W-1:0]  id_rn,
  input  logic [REG_W-1:0]  id_rm,
  input  logic              id_use_rn,
  input  logic              id_use_rm,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              ex_shift_imm,
  output logic [3:0]        ex_alu_op,
  output logic [1:0]        ex_mem_size,
  output logic              ex_mem_enable,
  output logic              ex_mem_rw,
  output logic              ex_load_inst,
  output logic              ex_s,
  output logic              ex_rf_enable,
  output logic              ex_b_instr,
  output logic              ex_b_l,
  output logic [DATA_W-1:0] ex_pa,
  output logic [DATA_W-1:0] ex_pb,
  output logic [DATA_W-1:0] ex_pd,
  output logic [23:0]       ex_imm,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_valid,
  output logic              ifid_hold
`ifdef ID_EX_PERF_COUNTERS_EN
  ,
  output logic [15:0]       bubble_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  ctrl_word_t        id_ctrl;
  ctrl_word_t        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] pa_q, pa_d, pb_q, pb_d, pd_q, pd_d;
  logic [23:0]       imm_q, imm_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              valid_q, valid_d;
  logic              haz;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .ex_valid     (valid_q),
    .ex_load_inst (ctrl_q.load_inst),
    .ex_rf_enable (ctrl_q.rf_enable),
    .ex_rd        (rd_q),
    .id_use_rn    (id_use_rn),
    .id_rn        (id_rn),
    .id_use_rm    (id_use_rm),
    .id_rm        (id_rm),
    .haz          (haz)
  );

  // Hazard holds IF/ID even when a simultaneous flush wins the EX slot;
  // squashing IF/ID is the upstream flush logic's job.
  assign ifid_hold = haz | ex_hold;

  always_comb begin
    id_ctrl.shift_imm  = id_shift_imm;
    id_ctrl.alu_op     = id_alu_op;
    id_ctrl.mem_size   = id_mem_size;
    id_ctrl.mem_enable = id_mem_enable;
    id_ctrl.mem_rw     = id_mem_rw;
    id_ctrl.load_inst  = id_load_inst;
    id_ctrl.s          = id_s;
    id_ctrl.rf_enable  = id_rf_enable;
    id_ctrl.b_instr    = id_b_instr;
    id_ctrl.b_l        = id_b_l;
  end

  always_comb begin
    // Default: hold (covers ex_hold=1, which overrides flush and hazard).
    ctrl_d  = ctrl_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    pd_d    = pd_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    valid_d = valid_q;
    if (!ex_hold) begin
      if (flush || haz) begin
        ctrl_d  = CTRL_NOP;
        pa_d    = '0;
        pb_d    = '0;
        pd_d    = '0;
        imm_d   = '0;
        rd_d    = '0;
        valid_d = 1'b0;
      end else begin
        ctrl_d  = id_ctrl;
        pa_d    = id_pa;
        pb_d    = id_pb;
        pd_d    = id_pd;
        imm_d   = id_imm;
        rd_d    = id_rd;
        valid_d = 1'b1;
        if (!id_cond_pass) begin
          ctrl_d  = CTRL_NOP;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q  <= CTRL_NOP;
      pa_q    <= '0;
      pb_q    <= '0;
      pd_q    <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      pd_q    <= pd_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
    end
  end

  assign ex_shift_imm  = ctrl_q.shift_imm;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_mem_size   = ctrl_q.mem_size;
  assign ex_mem_enable = ctrl_q.mem_enable;
  assign ex_mem_rw     = ctrl_q.mem_rw;
  assign ex_load_inst  = ctrl_q.load_inst;
  assign ex_s          = ctrl_q.s;
  assign ex_rf_enable  = ctrl_q.rf_enable;
  assign ex_b_instr    = ctrl_q.b_instr;
  assign ex_b_l        = ctrl_q.b_l;
  assign ex_pa         = pa_q;
  assign ex_pb         = pb_q;
  assign ex_pd         = pd_q;
  assign ex_imm        = imm_q;
  assign ex_rd         = rd_q;
  assign ex_valid      = valid_q;

`ifdef ID_EX_PERF_COUNTERS_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    // Only a hazard bubble that actually loads counts (flush outranks it).
    if (!ex_hold && !flush && haz && (bubble_cnt_q != 16'hFFFF))
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    if (!ex_hold && flush && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule
